// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window address generator
// and its sibling generators.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a flat channel-major input-buffer address.
    function automatic int addr_width(input int ch, input int h, input int w);
        return (ch * h * w > 1) ? $clog2(ch * h * w) : 1;
    endfunction

    // Signed pixel-coordinate width: enough magnitude for the largest
    // dimension plus padding, plus one sign bit.
    function automatic int coord_width(input int w, input int h, input int p_max);
        int m;
        m = (w > h) ? w : h;
        return $clog2(m + p_max + 1) + 1;
    endfunction

    // Width of a channel index, never narrower than one bit.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Nested kx / ky / c tap counter for one output pixel. kx is innermost, then
// ky, then c. The wrap flags mark the last value of each level so callers can
// detect the final tap of a pixel without extra comparators.
module conv_tap_counter
    import conv_pkg::*;
#(
    parameter int CH    = 2,
    parameter int K_MAX = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          advance,
    input  logic [$clog2(K_MAX+1)-1:0]    k,
    output logic [$clog2(K_MAX+1)-1:0]    kx,
    output logic [$clog2(K_MAX+1)-1:0]    ky,
    output logic [ch_width(CH)-1:0]       c,
    output logic                          kx_wrap,
    output logic                          ky_wrap,
    output logic                          c_wrap
);

    localparam int KW  = $clog2(K_MAX + 1);
    localparam int CHW = ch_width(CH);

    assign kx_wrap = (kx == k - KW'(1));
    assign ky_wrap = (ky == k - KW'(1));
    assign c_wrap  = (c == CHW'(CH - 1));

    // Step the innermost counter on every accepted beat and ripple carries outward.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            kx <= '0;
            ky <= '0;
            c  <= '0;
        end else if (advance) begin
            if (!kx_wrap) begin
                kx <= kx + KW'(1);
            end else begin
                kx <= '0;
                if (!ky_wrap) begin
                    ky <= ky + KW'(1);
                end else begin
                    ky <= '0;
                    if (!c_wrap) begin
                        c <= c + CHW'(1);
                    end else begin
                        c <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every output pixel of a 2-D convolution and emits one input-buffer
// address per beat for each channel and kernel tap, flagging taps that fall
// into the zero-padding border. Pixel origins are tracked incrementally so the
// loop never multiplies by a runtime value.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int IN_H  = 8,
    parameter int CH    = 2,
    parameter int K_MAX = 5,
    parameter int S_MAX = 3,
    parameter int P_MAX = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(K_MAX+1)-1:0]             cfg_kernel_width,
    input  logic [$clog2(S_MAX+1)-1:0]             cfg_stride,
    input  logic [$clog2(P_MAX+1)-1:0]             cfg_pad,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [addr_width(CH, IN_H, IN_W)-1:0]  out_addr,
    output logic                                   out_is_pad,
    output logic                                   out_last_tap,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   cfg_err
);

    localparam int KW    = $clog2(K_MAX + 1);
    localparam int SW    = $clog2(S_MAX + 1);
    localparam int PW    = $clog2(P_MAX + 1);
    localparam int AW    = addr_width(CH, IN_H, IN_W);
    localparam int CW    = coord_width(IN_W, IN_H, P_MAX);
    localparam int EW    = CW + 2;
    localparam int CHW   = ch_width(CH);
    localparam int PLANE = IN_H * IN_W;

    // Extended-width constants so window-extent sums never overflow.
    localparam logic signed [EW-1:0] IN_W_E  = EW'(IN_W);
    localparam logic signed [EW-1:0] IN_H_E  = EW'(IN_H);
    localparam logic signed [EW-1:0] K_MAX_E = EW'(K_MAX);
    localparam logic signed [EW-1:0] S_MAX_E = EW'(S_MAX);
    localparam logic signed [EW-1:0] P_MAX_E = EW'(P_MAX);

    state_t state, state_next;

    logic [KW-1:0]         k_q;
    logic [SW-1:0]         s_q;
    logic [PW-1:0]         p_q;
    logic signed [CW-1:0]  org_x, org_y;

    logic [KW-1:0]         kx, ky;
    logic [CHW-1:0]        c_idx;
    logic                  kx_wrap, ky_wrap, c_wrap;

    logic signed [EW-1:0]  req_k, req_s, req_p;
    logic                  cfg_illegal;
    logic                  start_ok, start_bad;

    logic signed [CW-1:0]  step_s, neg_p_q, neg_p_req;
    logic signed [EW-1:0]  org_x_e, org_y_e, k_e, s_e, p_e, ix_e, iy_e;
    logic [EW-1:0]         ix_u, iy_u;
    logic                  in_bounds;
    logic [AW-1:0]         addr_calc;

    logic                  tap_last, x_wrap, y_wrap, run_last, fire;

    // ---------------------------------------------------------------
    // Config legality, judged on the live cfg inputs at start time
    // ---------------------------------------------------------------
    assign req_k = $signed({{(EW-KW){1'b0}}, cfg_kernel_width});
    assign req_s = $signed({{(EW-SW){1'b0}}, cfg_stride});
    assign req_p = $signed({{(EW-PW){1'b0}}, cfg_pad});

    // Reject zero sizes, out-of-range values, and kernels wider than the padded map.
    always_comb begin
        cfg_illegal = (req_k == '0) || (req_s == '0) ||
                      (req_k > K_MAX_E) || (req_s > S_MAX_E) || (req_p > P_MAX_E) ||
                      (req_k > IN_W_E + req_p + req_p) ||
                      (req_k > IN_H_E + req_p + req_p);
    end

    assign start_ok  = (state == IDLE) && start && !cfg_illegal;
    assign start_bad = (state == IDLE) && start && cfg_illegal;

    // ---------------------------------------------------------------
    // Tap counter (kx innermost, then ky, then channel)
    // ---------------------------------------------------------------
    conv_tap_counter #(
        .CH    (CH),
        .K_MAX (K_MAX)
    ) u_tap_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .advance (fire),
        .k       (k_q),
        .kx      (kx),
        .ky      (ky),
        .c       (c_idx),
        .kx_wrap (kx_wrap),
        .ky_wrap (ky_wrap),
        .c_wrap  (c_wrap)
    );

    assign tap_last = kx_wrap && ky_wrap && c_wrap;

    // ---------------------------------------------------------------
    // Pixel origin arithmetic
    // ---------------------------------------------------------------
    assign step_s    = $signed({{(CW-SW){1'b0}}, s_q});
    assign neg_p_q   = -$signed({{(CW-PW){1'b0}}, p_q});
    assign neg_p_req = -$signed({{(CW-PW){1'b0}}, cfg_pad});

    assign org_x_e = {{2{org_x[CW-1]}}, org_x};
    assign org_y_e = {{2{org_y[CW-1]}}, org_y};
    assign k_e     = $signed({{(EW-KW){1'b0}}, k_q});
    assign s_e     = $signed({{(EW-SW){1'b0}}, s_q});
    assign p_e     = $signed({{(EW-PW){1'b0}}, p_q});

    // The next window along a row/column would spill past the padded edge.
    assign x_wrap   = (org_x_e + s_e + k_e) > (IN_W_E + p_e);
    assign y_wrap   = (org_y_e + s_e + k_e) > (IN_H_E + p_e);
    assign run_last = tap_last && x_wrap && y_wrap;

    assign ix_e = org_x_e + $signed({{(EW-KW){1'b0}}, kx});
    assign iy_e = org_y_e + $signed({{(EW-KW){1'b0}}, ky});
    assign ix_u = ix_e;
    assign iy_u = iy_e;

    assign in_bounds = !ix_e[EW-1] && (ix_e < IN_W_E) &&
                       !iy_e[EW-1] && (iy_e < IN_H_E);

    // Only meaningful when in_bounds; the multiplies are by elaboration constants.
    assign addr_calc = AW'(c_idx) * AW'(PLANE) + AW'(iy_u) * AW'(IN_W) + AW'(ix_u);

    // Latch the config on an accepted start and step the origins after each pixel's last tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            s_q   <= '0;
            p_q   <= '0;
            org_x <= '0;
            org_y <= '0;
        end else if (start_ok) begin
            k_q   <= cfg_kernel_width;
            s_q   <= cfg_stride;
            p_q   <= cfg_pad;
            org_x <= neg_p_req;
            org_y <= neg_p_req;
        end else if (fire && tap_last) begin
            if (x_wrap) begin
                org_x <= neg_p_q;
                if (!y_wrap) begin
                    org_y <= org_y + step_s;
                end
            end else begin
                org_x <= org_x + step_s;
            end
        end
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start only matters in IDLE, the final accepted beat ends RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !cfg_illegal) state_next = RUN;
            RUN:     if (fire && run_last)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat outputs are decoded from held counters, so a stall keeps them stable.
    always_comb begin
        out_valid    = 1'b0;
        out_addr     = '0;
        out_is_pad   = 1'b0;
        out_last_tap = 1'b0;
        out_last     = 1'b0;
        busy         = (state != IDLE);
        if (state == RUN) begin
            out_valid    = 1'b1;
            out_is_pad   = !in_bounds;
            out_addr     = in_bounds ? addr_calc : '0;
            out_last_tap = tap_last;
            out_last     = run_last;
        end
    end

    assign fire = out_valid && out_ready;

    // Registered status pulses: done follows the DONE cycle, cfg_err follows a rejected start.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= (state == DONE);
            cfg_err <= start_bad;
        end
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen. Two instances share stimulus:
// a 4x4 single-channel map and a 4x4 two-channel map. A loop-based reference
// model lists every expected beat for a config; one compare process checks the
// selected instance against it every cycle.
`timescale 1ns/1ps
module tb_conv_window_addr_gen;

    localparam int KW = 3;
    localparam int SW = 2;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_a, start_b;
    logic [KW-1:0] cfg_k;
    logic [SW-1:0] cfg_s;
    logic [PW-1:0] cfg_p;
    logic          out_ready;

    logic       a_valid, a_pad, a_lt, a_last, a_busy, a_done, a_err;
    logic [3:0] a_addr;
    logic       b_valid, b_pad, b_lt, b_last, b_busy, b_done, b_err;
    logic [4:0] b_addr;

    conv_window_addr_gen #(.IN_W(4), .IN_H(4), .CH(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .cfg_kernel_width(cfg_k), .cfg_stride(cfg_s), .cfg_pad(cfg_p),
        .out_valid(a_valid), .out_ready(out_ready), .out_addr(a_addr),
        .out_is_pad(a_pad), .out_last_tap(a_lt), .out_last(a_last),
        .busy(a_busy), .done(a_done), .cfg_err(a_err)
    );

    conv_window_addr_gen #(.IN_W(4), .IN_H(4), .CH(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .cfg_kernel_width(cfg_k), .cfg_stride(cfg_s), .cfg_pad(cfg_p),
        .out_valid(b_valid), .out_ready(out_ready), .out_addr(b_addr),
        .out_is_pad(b_pad), .out_last_tap(b_lt), .out_last(b_last),
        .busy(b_busy), .done(b_done), .cfg_err(b_err)
    );

    // View of whichever instance is under test.
    int          sel = 0;
    logic        m_valid, m_pad, m_lt, m_last, m_busy, m_done, m_err;
    logic [31:0] m_addr;
    always_comb begin
        if (sel == 0) begin
            m_valid = a_valid; m_pad = a_pad; m_lt = a_lt; m_last = a_last;
            m_busy = a_busy; m_done = a_done; m_err = a_err; m_addr = 32'(a_addr);
        end else begin
            m_valid = b_valid; m_pad = b_pad; m_lt = b_lt; m_last = b_last;
            m_busy = b_busy; m_done = b_done; m_err = b_err; m_addr = 32'(b_addr);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        bit pad;
        bit lt;
        bit last;
    } beat_t;

    beat_t expq[$];

    function automatic bit model_legal(input int k, input int s, input int p);
        return (k >= 1) && (s >= 1) && (k <= 5) && (s <= 3) && (p <= 2) && (k <= 4 + 2 * p);
    endfunction

    task automatic build_model(input int w, input int h, input int ch, input int k, input int s, input int p);
        int nox, noy, ix, iy;
        beat_t b;
        expq.delete();
        nox = (w + 2 * p - k) / s + 1;
        noy = (h + 2 * p - k) / s + 1;
        for (int oy = 0; oy < noy; oy++)
            for (int ox = 0; ox < nox; ox++)
                for (int c = 0; c < ch; c++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            ix = ox * s - p + kx;
                            iy = oy * s - p + ky;
                            b.pad  = !(ix >= 0 && ix < w && iy >= 0 && iy < h);
                            b.addr = b.pad ? 0 : c * w * h + iy * w + ix;
                            b.lt   = (c == ch - 1) && (ky == k - 1) && (kx == k - 1);
                            b.last = b.lt && (ox == nox - 1) && (oy == noy - 1);
                            expq.push_back(b);
                        end
    endtask

    // ---------------- compare process ----------------
    bit checking = 0;
    int cyc = 0;
    int beat_idx, done_count, done_cyc, last_acc_cyc, err_count, busy_seen;
    bit valid_seen;
    int acc_addr[$];
    bit acc_pad[$];

    function automatic int acc_at(input int i);
        return (i < acc_addr.size()) ? acc_addr[i] : -1;
    endfunction

    function automatic int pad_at(input int i);
        return (i < acc_pad.size()) ? int'(acc_pad[i]) : -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (checking) begin
                if (m_valid === 1'b1) begin
                    valid_seen = 1'b1;
                    if (beat_idx < expq.size()) begin
                        checkOutput($sformatf("beat%0d_addr", beat_idx), m_addr, 32'(expq[beat_idx].addr));
                        checkOutput($sformatf("beat%0d_pad", beat_idx), 32'(m_pad), 32'(expq[beat_idx].pad));
                        checkOutput($sformatf("beat%0d_last_tap", beat_idx), 32'(m_lt), 32'(expq[beat_idx].lt));
                        checkOutput($sformatf("beat%0d_last", beat_idx), 32'(m_last), 32'(expq[beat_idx].last));
                        if (out_ready === 1'b1) begin
                            acc_addr.push_back(int'(m_addr));
                            acc_pad.push_back(m_pad);
                            if (m_last === 1'b1) last_acc_cyc = cyc;
                            beat_idx++;
                        end
                    end else begin
                        checkOutput("extra_beat_valid", 32'(m_valid), 32'd0);
                    end
                end else if (valid_seen && beat_idx < expq.size()) begin
                    checkOutput("valid_held_in_run", 32'(m_valid), 32'd1);
                end
                if (m_done === 1'b1) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (m_err === 1'b1) err_count++;
                if (m_busy === 1'b1) busy_seen++;
            end
        end
    end

    // ---------------- ready driver ----------------
    bit rand_ready = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic reset_tracking();
        beat_idx = 0; done_count = 0; done_cyc = -1; last_acc_cyc = -1;
        err_count = 0; busy_seen = 0; valid_seen = 1'b0;
        acc_addr.delete();
        acc_pad.delete();
    endtask

    // Run one start request on the selected instance and check the whole run.
    task automatic applyStimulus(input int s_sel, input int k, input int s, input int p, input bit rnd);
        int  lim;
        bit  legal;
        legal = model_legal(k, s, p);
        sel = s_sel;
        rand_ready = rnd;
        if (legal) build_model(4, 4, (s_sel == 0) ? 1 : 2, k, s, p);
        else expq.delete();
        reset_tracking();
        @(posedge clk); #1;
        cfg_k = KW'(k); cfg_s = SW'(s); cfg_p = PW'(p);
        if (s_sel == 0) start_a = 1'b1; else start_b = 1'b1;
        checking = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        cfg_k = KW'($urandom); cfg_s = SW'($urandom); cfg_p = PW'($urandom);
        if (legal) begin
            checkOutput("first_valid_latency", 32'(m_valid), 32'd1);
            checkOutput("busy_in_run", 32'(m_busy), 32'd1);
            // a start while running must be ignored
            if (s_sel == 0) start_a = 1'b1; else start_b = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            lim = 0;
            while (beat_idx < expq.size() && lim < 4000) begin
                @(posedge clk); #1;
                lim++;
            end
            checkOutput("run_beat_count", 32'(beat_idx), 32'(expq.size()));
            repeat (4) @(posedge clk);
            #1;
            checkOutput("done_count", 32'(done_count), 32'd1);
            checkOutput("done_latency", 32'(done_cyc - last_acc_cyc), 32'd2);
            checkOutput("no_cfg_err", 32'(err_count), 32'd0);
        end else begin
            checkOutput("cfg_err_pulse", 32'(m_err), 32'd1);
            checkOutput("illegal_no_valid", 32'(m_valid), 32'd0);
            repeat (4) @(posedge clk);
            #1;
            checkOutput("cfg_err_once", 32'(err_count), 32'd1);
            checkOutput("illegal_busy", 32'(busy_seen), 32'd0);
            checkOutput("illegal_beats", 32'(acc_addr.size()), 32'd0);
            checkOutput("illegal_done", 32'(done_count), 32'd0);
        end
        checking = 1'b0;
        rand_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp9 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int exp8 [8] = '{0, 1, 4, 5, 16, 17, 20, 21};
        int lim, dcount;
        int k, s, p;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        cfg_k = '0; cfg_s = '0; cfg_p = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_a_valid", 32'(a_valid), 32'd0);
        checkOutput("reset_a_addr", 32'(a_addr), 32'd0);
        checkOutput("reset_a_pad", 32'(a_pad), 32'd0);
        checkOutput("reset_a_last_tap", 32'(a_lt), 32'd0);
        checkOutput("reset_a_last", 32'(a_last), 32'd0);
        checkOutput("reset_a_busy", 32'(a_busy), 32'd0);
        checkOutput("reset_a_done", 32'(a_done), 32'd0);
        checkOutput("reset_a_cfg_err", 32'(a_err), 32'd0);
        checkOutput("reset_b_valid", 32'(b_valid), 32'd0);
        checkOutput("reset_b_addr", 32'(b_addr), 32'd0);
        checkOutput("reset_b_busy", 32'(b_busy), 32'd0);
        checkOutput("reset_b_done", 32'(b_done), 32'd0);
        rst = 1'b0;

        $display("[TB] case 1: 4x4 ch1 k3 s1 p0");
        applyStimulus(0, 3, 1, 0, 1'b0);
        checkOutput("model_case1_size", 32'(expq.size()), 32'd36);
        checkOutput("model_case1_lt_beat9", 32'(expq[8].lt), 32'd1);
        for (int i = 0; i < 9; i++) checkOutput($sformatf("case1_addr%0d", i), 32'(acc_at(i)), 32'(exp9[i]));
        checkOutput("case1_pixel2_first", 32'(acc_at(9)), 32'd1);
        checkOutput("case1_last_addr", 32'(acc_at(35)), 32'd15);
        checkOutput("case1_count", 32'(acc_addr.size()), 32'd36);

        $display("[TB] case 2: 4x4 ch1 k3 s2 p1");
        applyStimulus(0, 3, 2, 1, 1'b0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("case2_pad%0d", i), 32'(pad_at(i)), 32'd1);
        checkOutput("case2_beat5_addr", 32'(acc_at(4)), 32'd0);
        checkOutput("case2_beat5_pad", 32'(pad_at(4)), 32'd0);
        checkOutput("case2_pixel2_pad", 32'(pad_at(9)), 32'd1);
        checkOutput("case2_beat13_addr", 32'(acc_at(12)), 32'd1);
        checkOutput("case2_count", 32'(acc_addr.size()), 32'd36);

        $display("[TB] case 3: 4x4 ch2 k2 s2 p0");
        applyStimulus(1, 2, 2, 0, 1'b0);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("case3_addr%0d", i), 32'(acc_at(i)), 32'(exp8[i]));
        checkOutput("case3_count", 32'(acc_addr.size()), 32'd32);

        $display("[TB] case 4: case 1 with random back-pressure");
        applyStimulus(0, 3, 1, 0, 1'b1);
        checkOutput("case4_count", 32'(acc_addr.size()), 32'd36);
        checkOutput("case4_last_addr", 32'(acc_at(35)), 32'd15);

        $display("[TB] case 5: reset on beat 10");
        sel = 0;
        rand_ready = 1'b0;
        build_model(4, 4, 1, 3, 1, 0);
        reset_tracking();
        @(posedge clk); #1;
        cfg_k = 3'd3; cfg_s = 2'd1; cfg_p = 2'd0; start_a = 1'b1;
        checking = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lim = 0;
        while (beat_idx < 9 && lim < 200) begin
            @(posedge clk); #1;
            lim++;
        end
        checkOutput("abort_reached_beat10", 32'(beat_idx), 32'd9);
        checkOutput("abort_beat10_addr", m_addr, 32'd1);
        checking = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_valid", 32'(m_valid), 32'd0);
        checkOutput("abort_busy", 32'(m_busy), 32'd0);
        checkOutput("abort_done", 32'(m_done), 32'd0);
        dcount = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_done === 1'b1 || m_valid === 1'b1) dcount++;
        end
        checkOutput("abort_quiet", 32'(dcount), 32'd0);
        applyStimulus(0, 3, 1, 0, 1'b0);
        checkOutput("replay_first_addr", 32'(acc_at(0)), 32'd0);
        checkOutput("replay_count", 32'(acc_addr.size()), 32'd36);

        $display("[TB] case 6: illegal configs");
        applyStimulus(0, 0, 1, 0, 1'b0);
        applyStimulus(0, 7, 1, 0, 1'b0);

        $display("[TB] random configs");
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(1, 5);
                s = $urandom_range(1, 3);
                p = $urandom_range(0, 2);
            end else begin
                k = $urandom_range(0, 7);
                s = $urandom_range(0, 3);
                p = $urandom_range(0, 3);
            end
            applyStimulus($urandom_range(0, 1), k, s, p, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #5000000;
        errors++;
        $display("[TB] FAIL watchdog_timeout actual=expired required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
